// File: rtl/uart_fpu_pkg.sv
// Shared types and constants for the UART <-> FPU frame sequencer.
package uart_fpu_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        S_RECV  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    // FPU operation codes carried in the opcode byte
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    // Error codes reported on o_err_code
    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    // Opcode + 4 bytes operand A + 4 bytes operand B
    localparam int FRAME_BYTES = 9;

endpackage

// File: rtl/uart_fpu_timeout.sv
// Inter-byte idle watchdog: reloads on every accepted byte, counts down while
// enabled and pulses o_expire in the last idle cycle of the allowed gap.
module uart_fpu_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_reload,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Down-counter: load full gap on a byte, decrement while waiting for the next one
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_reload) begin
            cnt <= CNT_LOAD;
        end else if (i_enable && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // A byte arriving in the final cycle wins over expiry
    assign o_expire = i_enable && !i_reload && (cnt == CNT_ONE);

endmodule

// File: rtl/uart_fpu_ctrl.sv
// Frame sequencer: collects opcode + two 32-bit operands from UART RX, issues
// one FPU operation, and streams the 32-bit result back to UART TX LSB first.
module uart_fpu_ctrl
    import uart_fpu_pkg::*;
#(
    parameter int SIZE_DATA_I = 8,
    parameter int SIZE_DATA_O = 32,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx_valid,
    input  logic [SIZE_DATA_I-1:0] i_rx_data,
    output logic                   o_fpu_start,
    output logic [1:0]             o_fpu_op,
    output logic [SIZE_DATA_O-1:0] o_op_a,
    output logic [SIZE_DATA_O-1:0] o_op_b,
    input  logic                   i_fpu_done,
    input  logic [SIZE_DATA_O-1:0] i_fpu_result,
    output logic                   o_tx_valid,
    output logic [SIZE_DATA_I-1:0] o_tx_data,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_err,
    output logic [1:0]             o_err_code
);

    localparam logic [3:0] IDX_LAST = 4'(FRAME_BYTES - 1);

    state_t                 state, state_nxt;
    logic [3:0]             idx, idx_nxt;
    logic [1:0]             tx_idx, tx_idx_nxt;
    logic                   start_q;
    logic                   err_q, err_nxt;
    logic [1:0]             err_code_q, err_code_nxt;
    op_t                    op_q;
    logic [SIZE_DATA_O-1:0] op_a_q, op_b_q, result_q;

    logic                   rx_accept;
    logic                   opcode_bad;
    logic                   tmo_expire;
    logic [1:0]             lane;

    assign rx_accept  = (state == S_RECV) && i_rx_valid;
    assign opcode_bad = rx_accept && (idx == 4'd0) && (|i_rx_data[SIZE_DATA_I-1:2]);
    // Frame indices 1..4 and 5..8 both map onto operand byte lanes 0..3
    assign lane       = idx[1:0] - 2'd1;

    uart_fpu_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable ((state == S_RECV) && (idx != 4'd0)),
        .i_reload (rx_accept),
        .o_expire (tmo_expire)
    );

    // Next-state, byte indices and error strobe
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        tx_idx_nxt   = tx_idx;
        err_nxt      = 1'b0;
        err_code_nxt = err_code_q;
        case (state)
            S_RECV: begin
                if (rx_accept) begin
                    if (opcode_bad) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_OPCODE;
                    end else if (idx == IDX_LAST) begin
                        idx_nxt   = 4'd0;
                        state_nxt = S_START;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end else if (tmo_expire) begin
                    idx_nxt      = 4'd0;
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_fpu_done) state_nxt = S_SEND;
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    tx_idx_nxt = tx_idx + 2'd1;
                    if (tx_idx == 2'd3) state_nxt = S_RECV;
                end
            end
            default: state_nxt = S_RECV;
        endcase
        if (i_rx_valid && (state != S_RECV)) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_OVERRUN;
        end
    end

    // Control registers: state, indices, start and error pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_RECV;
            idx        <= 4'd0;
            tx_idx     <= 2'd0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            tx_idx     <= tx_idx_nxt;
            start_q    <= (state_nxt == S_START);
            err_q      <= err_nxt;
            err_code_q <= err_code_nxt;
        end
    end

    // Frame and result capture; operands stay put until the next frame overwrites them
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q     <= OP_ADD;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else begin
            if (rx_accept && !opcode_bad) begin
                if (idx == 4'd0) begin
                    op_q <= op_t'(i_rx_data[1:0]);
                end else if (idx < 4'd5) begin
                    op_a_q[lane*SIZE_DATA_I +: SIZE_DATA_I] <= i_rx_data;
                end else begin
                    op_b_q[lane*SIZE_DATA_I +: SIZE_DATA_I] <= i_rx_data;
                end
            end
            if ((state == S_WAIT) && i_fpu_done) begin
                result_q <= i_fpu_result;
            end
        end
    end

    assign o_fpu_start = start_q;
    assign o_fpu_op    = op_q;
    assign o_op_a      = op_a_q;
    assign o_op_b      = op_b_q;
    assign o_tx_valid  = (state == S_SEND);
    assign o_tx_data   = result_q[tx_idx*SIZE_DATA_I +: SIZE_DATA_I];
    assign o_busy      = (state != S_RECV);
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;

endmodule

// File: tb/tb_uart_fpu_ctrl.sv
// Directed bench for uart_fpu_ctrl: frames, opcode errors, timeout, TX stall
// with overrun, and reset while waiting on the FPU.
module tb_uart_fpu_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_fpu_start;
    logic [1:0]  o_fpu_op;
    logic [31:0] o_op_a;
    logic [31:0] o_op_b;
    logic        i_fpu_done;
    logic [31:0] i_fpu_result;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_err;
    logic [1:0]  o_err_code;

    int checks   = 0;
    int failures = 0;

    int         start_cnt = 0;
    int         err_cnt   = 0;
    logic [7:0] tx_log[$];

    uart_fpu_ctrl #(
        .SIZE_DATA_I(8),
        .SIZE_DATA_O(32),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_fpu_start  (o_fpu_start),
        .o_fpu_op     (o_fpu_op),
        .o_op_a       (o_op_a),
        .o_op_b       (o_op_b),
        .i_fpu_done   (i_fpu_done),
        .i_fpu_result (i_fpu_result),
        .o_tx_valid   (o_tx_valid),
        .o_tx_data    (o_tx_data),
        .i_tx_ready   (i_tx_ready),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_err_code   (o_err_code)
    );

    always #5 clk = ~clk;

    // Passive monitor on the falling edge: start pulses, error pulses, accepted TX bytes
    always @(negedge clk) begin
        if (o_fpu_start) start_cnt++;
        if (o_err) err_cnt++;
        if (o_tx_valid && i_tx_ready) tx_log.push_back(o_tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    endtask

    // Called in the start-pulse cycle; answers after dly cycles and drains TX
    task automatic finish_op(input logic [31:0] res, input int dly, output bit ok);
        repeat (dly) tick();
        i_fpu_done   = 1'b1;
        i_fpu_result = res;
        tick();
        i_fpu_done = 1'b0;
        for (int n = 0; n < 20 && o_busy; n++) tick();
        ok = !o_busy;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({o_fpu_start, o_fpu_op, o_op_a, o_op_b, o_tx_valid, o_tx_data, o_busy, o_err, o_err_code} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got start=%b op=%0d a=%h b=%h txv=%b txd=%h busy=%b err=%b code=%0d exp all zero",
                     o_fpu_start, o_fpu_op, o_op_a, o_op_b, o_tx_valid, o_tx_data, o_busy, o_err, o_err_code);
        end
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got busy=%b err=%b exp 0 0", o_busy, o_err);
        end
    endtask

    task automatic test_basic();
        int          s0, base;
        logic [31:0] got;
        s0   = start_cnt;
        base = tx_log.size();
        i_tx_ready = 1'b1;
        send_frame(8'h00, 32'h3F80_0000, 32'h4000_0000);
        checks++;
        if (o_fpu_start !== 1'b1 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_start got start=%b busy=%b exp 1 1", o_fpu_start, o_busy);
        end
        checks++;
        if (o_op_a !== 32'h3F80_0000 || o_op_b !== 32'h4000_0000 || o_fpu_op !== 2'd0) begin
            failures++;
            $display("FAIL basic_operands got a=%h b=%h op=%0d exp a=3f800000 b=40000000 op=0", o_op_a, o_op_b, o_fpu_op);
        end
        tick();
        checks++;
        if (o_fpu_start !== 1'b0 || o_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_wait got start=%b txv=%b exp 0 0", o_fpu_start, o_tx_valid);
        end
        tick();
        i_fpu_done   = 1'b1;
        i_fpu_result = 32'h4040_0000;
        tick();
        i_fpu_done = 1'b0;
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h00) begin
            failures++;
            $display("FAIL basic_tx_first got txv=%b txd=%h exp 1 00", o_tx_valid, o_tx_data);
        end
        repeat (4) tick();
        checks++;
        if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got busy=%b txv=%b exp 0 0", o_busy, o_tx_valid);
        end
        got = '0;
        for (int i = 0; i < 4; i++) if (base + i < tx_log.size()) got[8*i +: 8] = tx_log[base + i];
        checks++;
        if (tx_log.size() != base + 4 || got !== 32'h4040_0000) begin
            failures++;
            $display("FAIL basic_tx_bytes got n=%0d word=%h exp n=4 word=40400000", tx_log.size() - base, got);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL basic_start_count got %0d exp 1", start_cnt - s0);
        end
    endtask

    task automatic test_bad_opcode();
        int e0;
        bit ok;
        e0 = err_cnt;
        send_byte(8'h05);
        checks++;
        if (o_err !== 1'b1 || o_err_code !== 2'd1) begin
            failures++;
            $display("FAIL badop_err got err=%b code=%0d exp 1 1", o_err, o_err_code);
        end
        send_frame(8'h02, 32'h3F80_0000, 32'h4000_0000);
        checks++;
        if (o_fpu_start !== 1'b1 || o_fpu_op !== 2'd2 || o_op_a !== 32'h3F80_0000 || o_op_b !== 32'h4000_0000) begin
            failures++;
            $display("FAIL badop_frame got start=%b op=%0d a=%h b=%h exp 1 2 3f800000 40000000",
                     o_fpu_start, o_fpu_op, o_op_a, o_op_b);
        end
        finish_op(32'h4000_0000, 1, ok);
        checks++;
        if (!ok || err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL badop_complete got done=%0d errs=%0d exp 1 1", ok, err_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        int          e0, base;
        bit          ok;
        logic [31:0] got;
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TMO - 1) tick();
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got err=%b exp 0", o_err);
        end
        tick();
        checks++;
        if (o_err !== 1'b1 || o_err_code !== 2'd2) begin
            failures++;
            $display("FAIL timeout_err got err=%b code=%0d exp 1 2", o_err, o_err_code);
        end
        tick();
        checks++;
        if (o_err !== 1'b0 || o_err_code !== 2'd2) begin
            failures++;
            $display("FAIL timeout_pulse got err=%b code=%0d exp 0 2", o_err, o_err_code);
        end
        // Fresh frame; byte 2 arrives in the last cycle of the allowed gap
        e0   = err_cnt;
        base = tx_log.size();
        send_byte(8'h01);
        send_byte(8'hA0);
        repeat (TMO - 1) tick();
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i));
        checks++;
        if (o_fpu_start !== 1'b1 || o_fpu_op !== 2'd1 || o_op_a !== 32'hA3A2_A1A0 || o_op_b !== 32'hB3B2_B1B0) begin
            failures++;
            $display("FAIL timeout_edge_frame got start=%b op=%0d a=%h b=%h exp 1 1 a3a2a1a0 b3b2b1b0",
                     o_fpu_start, o_fpu_op, o_op_a, o_op_b);
        end
        checks++;
        if (err_cnt != e0) begin
            failures++;
            $display("FAIL timeout_edge_noerr got errs=%0d exp 0", err_cnt - e0);
        end
        finish_op(32'hA1B2_C3D4, 3, ok);
        got = '0;
        for (int i = 0; i < 4; i++) if (base + i < tx_log.size()) got[8*i +: 8] = tx_log[base + i];
        checks++;
        if (!ok || tx_log.size() != base + 4 || got !== 32'hA1B2_C3D4) begin
            failures++;
            $display("FAIL timeout_result got done=%0d n=%0d word=%h exp 1 4 a1b2c3d4", ok, tx_log.size() - base, got);
        end
    endtask

    task automatic test_tx_stall();
        int          base;
        logic [31:0] got;
        base = tx_log.size();
        i_tx_ready = 1'b0;
        send_frame(8'h03, 32'h0000_0001, 32'h0000_0002);
        tick();
        i_fpu_done   = 1'b1;
        i_fpu_result = 32'h1234_0056;
        tick();
        i_fpu_done = 1'b0;
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h56) begin
            failures++;
            $display("FAIL stall_byte0 got txv=%b txd=%h exp 1 56", o_tx_valid, o_tx_data);
        end
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h00 || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got txv=%b txd=%h busy=%b exp 1 00 1", c, o_tx_valid, o_tx_data, o_busy);
            end
            if (c == 2) begin
                i_rx_valid = 1'b1;
                i_rx_data  = 8'h77;
            end
            if (c == 3) begin
                checks++;
                if (o_err !== 1'b1 || o_err_code !== 2'd3) begin
                    failures++;
                    $display("FAIL stall_overrun got err=%b code=%0d exp 1 3", o_err, o_err_code);
                end
            end
            tick();
            i_rx_valid = 1'b0;
        end
        i_tx_ready = 1'b1;
        for (int n = 0; n < 20 && o_busy; n++) tick();
        got = '0;
        for (int i = 0; i < 4; i++) if (base + i < tx_log.size()) got[8*i +: 8] = tx_log[base + i];
        checks++;
        if (o_busy !== 1'b0 || tx_log.size() != base + 4 || got !== 32'h1234_0056) begin
            failures++;
            $display("FAIL stall_bytes got busy=%b n=%0d word=%h exp 0 4 12340056", o_busy, tx_log.size() - base, got);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = tx_log.size();
        send_frame(8'h03, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        tick();
        checks++;
        if (o_busy !== 1'b1 || o_fpu_op !== 2'd3) begin
            failures++;
            $display("FAIL rstmid_wait got busy=%b op=%0d exp 1 3", o_busy, o_fpu_op);
        end
        i_rst = 1'b1;
        tick();
        checks++;
        if ({o_fpu_start, o_fpu_op, o_op_a, o_op_b, o_tx_valid, o_tx_data, o_busy, o_err, o_err_code} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got op=%0d a=%h b=%h txv=%b busy=%b code=%0d exp all zero",
                     o_fpu_op, o_op_a, o_op_b, o_tx_valid, o_busy, o_err_code);
        end
        i_rst = 1'b0;
        tick();
        i_fpu_done   = 1'b1;
        i_fpu_result = 32'hDEAD_BEEF;
        tick();
        i_fpu_done = 1'b0;
        repeat (6) tick();
        checks++;
        if (tx_log.size() != base || o_busy !== 1'b0 || o_tx_valid !== 1'b0 || o_tx_data !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_late_done got txn=%0d busy=%b txv=%b txd=%h exp 0 0 0 00",
                     tx_log.size() - base, o_busy, o_tx_valid, o_tx_data);
        end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_rx_valid   = 1'b0;
        i_rx_data    = 8'h00;
        i_fpu_done   = 1'b0;
        i_fpu_result = 32'h0;
        i_tx_ready   = 1'b0;
        test_reset();
        test_basic();
        test_bad_opcode();
        test_timeout();
        test_tx_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
